// File: rtl/flit_credit_tx.sv
// Credit-based flit transmitter: pops a non-showahead scfifo while downstream
// credits remain and drives each popped flit onto the link two cycles after the pop.
module flit_credit_tx #(
    parameter int lpm_width = 32,
    parameter int CREDITS   = 4,
    parameter int CNT_W     = 3
) (
    input  logic                 clock,
    input  logic                 sclr,
    input  logic [lpm_width-1:0] fifo_q,
    input  logic                 fifo_empty,
    output logic                 fifo_rdreq,
    output logic [lpm_width-1:0] link_data,
    output logic                 link_valid,
    input  logic                 credit_in,
    output logic [CNT_W-1:0]     credits,
    output logic [15:0]          flit_cnt,
    output logic                 credit_err
);

    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

    logic [CNT_W-1:0]     credits_q, credits_d;
    logic                 credit_err_q, credit_err_d;
    logic                 rd_pend_q;
    logic                 link_valid_q;
    logic [lpm_width-1:0] link_data_q;
    logic [15:0]          flit_cnt_q;
    logic                 rdreq;

    // A credit returned this cycle only becomes usable next cycle.
    assign rdreq = !fifo_empty && (credits_q != '0) && !sclr;

    always_comb begin
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        if (rdreq && !credit_in) begin
            credits_d = credits_q - 1'b1;
        end else if (credit_in && !rdreq) begin
            if (credits_q == CRED_MAX) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end
    end

    // Credit/control state
    always_ff @(posedge clock) begin
        if (sclr) begin
            credits_q    <= CRED_MAX;
            credit_err_q <= 1'b0;
            rd_pend_q    <= 1'b0;
        end else begin
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
            rd_pend_q    <= rdreq;
        end
    end

    // Link stage: fifo_q is valid the cycle after the pop, captured here
    always_ff @(posedge clock) begin
        if (sclr) begin
            link_valid_q <= 1'b0;
            link_data_q  <= '0;
            flit_cnt_q   <= '0;
        end else begin
            link_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                link_data_q <= fifo_q;
            end
            if (link_valid_q) begin
                flit_cnt_q <= flit_cnt_q + 16'd1;
            end
        end
    end

    assign fifo_rdreq = rdreq;
    assign link_data  = link_data_q;
    assign link_valid = link_valid_q;
    assign credits    = credits_q;
    assign flit_cnt   = flit_cnt_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_flit_credit_tx.sv
// Directed and random bench for flit_credit_tx with a behavioural scfifo model
// and a scoreboard of flits in expected link order.
module tb_flit_credit_tx;

    logic        clock = 1'b0;
    logic        sclr;
    logic [31:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic [31:0] link_data;
    logic        link_valid;
    logic        credit_in;
    logic [2:0]  credits;
    logic [15:0] flit_cnt;
    logic        credit_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] fmem [0:2047];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        hold_empty;
    logic [31:0] exp_q [$];

    flit_credit_tx #(.lpm_width(32), .CREDITS(4), .CNT_W(3)) dut (
        .clock      (clock),
        .sclr       (sclr),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .link_data  (link_data),
        .link_valid (link_valid),
        .credit_in  (credit_in),
        .credits    (credits),
        .flit_cnt   (flit_cnt),
        .credit_err (credit_err)
    );

    always #5 clock = ~clock;

    // Non-showahead FIFO: data appears the cycle after the pop
    assign fifo_empty = (wr_ptr == rd_ptr) || hold_empty;
    always @(posedge clock) begin
        if (fifo_rdreq) begin
            fifo_q <= fmem[rd_ptr[10:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        fmem[wr_ptr[10:0]] = d;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(d);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (link_valid) begin
            if (exp_q.size() == 0) check("link_unexpected", 32'd1, 32'd0);
            else check("link_data", link_data, exp_q.pop_front());
        end
        if (credits > 3'd4) check("credits_bound", 32'(credits), 32'd4);
    end

    initial begin
        int nrd, nlv, first_lv, last_lv, delivered, owed, pushed, cyc;
        logic [31:0] tmp;
        fifo_q     = '0;
        sclr       = 1'b1;
        credit_in  = 1'b0;
        hold_empty = 1'b0;
        tick();
        tick();
        check("rst_credits", 32'(credits), 32'd4);
        check("rst_link_valid", 32'(link_valid), 32'd0);
        check("rst_link_data", link_data, 32'd0);
        check("rst_flit_cnt", 32'(flit_cnt), 32'd0);
        check("rst_credit_err", 32'(credit_err), 32'd0);

        // Single flit
        push(32'hA5A5A5A5);
        #1 check("rdreq_in_sclr", 32'(fifo_rdreq), 32'd0);
        sclr = 1'b0;
        #1 check("single_rdreq_c0", 32'(fifo_rdreq), 32'd1);
        tick();
        check("single_c1_valid", 32'(link_valid), 32'd0);
        check("single_c1_credits", 32'(credits), 32'd3);
        check("single_c1_rdreq_empty", 32'(fifo_rdreq), 32'd0);
        tick();
        check("single_c2_valid", 32'(link_valid), 32'd1);
        check("single_c2_data", link_data, 32'hA5A5A5A5);
        tick();
        check("single_flit_cnt", 32'(flit_cnt), 32'd1);
        check("single_hold_data", link_data, 32'hA5A5A5A5);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        check("restore_credits", 32'(credits), 32'd4);

        // Credit exhaustion
        for (int i = 0; i < 6; i++) push(32'h1000_0000 + i);
        nrd = 0; nlv = 0; first_lv = -1; last_lv = -1;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (fifo_rdreq) nrd++;
            if (link_valid) begin
                nlv++;
                if (first_lv < 0) first_lv = i;
                last_lv = i;
            end
            tick();
        end
        check("exh_rdreq_count", nrd, 32'd4);
        check("exh_valid_count", nlv, 32'd4);
        check("exh_back_to_back", last_lv - first_lv, 32'd3);
        check("exh_credits", 32'(credits), 32'd0);
        check("exh_rdreq_low", 32'(fifo_rdreq), 32'd0);

        // Credit return
        credit_in = 1'b1;
        #1 check("ret_same_cycle_rdreq", 32'(fifo_rdreq), 32'd0);
        tick();
        credit_in = 1'b0;
        check("ret_credits1", 32'(credits), 32'd1);
        #1 check("ret_rdreq", 32'(fifo_rdreq), 32'd1);
        tick();
        check("ret_credits0", 32'(credits), 32'd0);
        check("ret_rdreq_low", 32'(fifo_rdreq), 32'd0);
        tick();
        check("ret_fifth_valid", 32'(link_valid), 32'd1);

        // Drain 6th flit, then bring credits to 2
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        tick(); tick(); tick(); tick();
        credit_in = 1'b1;
        tick(); tick();
        credit_in = 1'b0;
        check("sim_credits_pre", 32'(credits), 32'd2);

        // Simultaneous pop and credit return
        push(32'h5555_AAAA);
        credit_in = 1'b1;
        #1 check("sim_rdreq", 32'(fifo_rdreq), 32'd1);
        tick();
        credit_in = 1'b0;
        check("sim_credits_hold", 32'(credits), 32'd2);
        credit_in = 1'b1;
        tick(); tick();
        credit_in = 1'b0;
        check("sim_credits_full", 32'(credits), 32'd4);
        check("sim_err_clear", 32'(credit_err), 32'd0);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        check("ovf_credits", 32'(credits), 32'd4);
        check("ovf_err", 32'(credit_err), 32'd1);
        tick(); tick();
        check("ovf_err_sticky", 32'(credit_err), 32'd1);

        // Reset while a read is pending
        push(32'hDEAD_BEEF);
        #1 check("rstmid_rdreq", 32'(fifo_rdreq), 32'd1);
        tick();
        sclr = 1'b1;
        credit_in = 1'b1;
        check("rstmid_scoreboard", exp_q.size(), 32'd1);
        if (exp_q.size() != 0) tmp = exp_q.pop_front();
        tick();
        sclr = 1'b0;
        credit_in = 1'b0;
        check("rstmid_valid", 32'(link_valid), 32'd0);
        check("rstmid_credits", 32'(credits), 32'd4);
        check("rstmid_flit_cnt", 32'(flit_cnt), 32'd0);
        check("rstmid_err", 32'(credit_err), 32'd0);
        tick();
        check("rstmid_dropped", 32'(link_valid), 32'd0);

        // Random ordering stress
        delivered = 0; owed = 0; pushed = 0; cyc = 0;
        while (delivered < 1000 && cyc < 20000) begin
            if (link_valid) begin
                delivered++;
                owed++;
            end
            if (owed > 0 && $urandom_range(1, 0) == 1) begin
                credit_in = 1'b1;
                owed--;
            end else begin
                credit_in = 1'b0;
            end
            if (pushed < 1000 && $urandom_range(3, 0) != 0) begin
                push($urandom);
                pushed++;
            end
            hold_empty = ($urandom_range(3, 0) == 0);
            tick();
            cyc++;
        end
        hold_empty = 1'b0;
        check("stress_delivered", delivered, 32'd1000);
        while (owed > 0) begin
            credit_in = 1'b1;
            owed--;
            tick();
        end
        credit_in = 1'b0;
        tick(); tick();
        check("stress_flit_cnt", 32'(flit_cnt), 32'd1000);
        check("stress_credits", 32'(credits), 32'd4);
        check("stress_err", 32'(credit_err), 32'd0);
        check("stress_scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
